// File: rtl/pixel_compositor.sv
// Pixel compositor: priority-merges palette indices, maps them to 12-bit RGB inside the
// visible window, and counts player/obstacle overlap per frame to report collisions.
module pixel_compositor #(
  parameter int CIDXW    = 3,
  parameter int IN_LAT   = 1,
  parameter int H_START  = 144,
  parameter int H_END    = 783,
  parameter int V_START  = 35,
  parameter int V_END    = 514,
  parameter int COLL_MIN = 4
) (
  input  logic           Clk,
  input  logic           Reset,
  input  logic [3:0]     state,
  input  logic [9:0]     hc,
  input  logic [9:0]     vc,
  input  logic [CIDXW:0] level_pix,
  input  logic [CIDXW:0] obstacle_pix,
  input  logic [CIDXW:0] player_pix,
  output logic [3:0]     vgaR,
  output logic [3:0]     vgaG,
  output logic [3:0]     vgaB,
  output logic           frame_tick,
  output logic           collision,
  output logic [7:0]     hit_count
);

  localparam int         IW       = CIDXW + 1;
  localparam logic [9:0] H_LO     = 10'(H_START);
  localparam logic [9:0] H_HI     = 10'(H_END);
  localparam logic [9:0] V_LO     = 10'(V_START);
  localparam logic [9:0] V_HI     = 10'(V_END);
  localparam logic [9:0] EOF_V    = 10'(V_END + 1);
  localparam logic [7:0] COLL_THR = 8'(COLL_MIN);

  function automatic logic [11:0] palette(input logic [IW-1:0] idx);
    case (idx)
      IW'(0):  palette = 12'hFFF;
      IW'(1):  palette = 12'h000;
      IW'(2):  palette = 12'hF80;
      IW'(3):  palette = 12'h0A0;
      IW'(7):  palette = 12'h555;
      default: palette = 12'hF0F;
    endcase
  endfunction

  logic          vis_raw_s;
  logic          vis_al_s;
  logic [IW-1:0] pix_idx_s;
  logic          running_s;
  logic          overlap_s;
  logic          eof_s;

  logic [11:0]   rgb_d, rgb_q;
  logic [7:0]    hit_d, hit_q;
  logic          flag_d, flag_q;
  logic          tick_d, tick_q;
  logic          coll_d, coll_q;

  assign vis_raw_s = (hc >= H_LO) && (hc <= H_HI) && (vc >= V_LO) && (vc <= V_HI);

  // Delay the window flag so it lines up with the lagging pixel-index inputs.
  generate
    if (IN_LAT == 0) begin : g_nolat
      assign vis_al_s = vis_raw_s;
    end else begin : g_lat
      logic [IN_LAT-1:0] vis_pipe_d, vis_pipe_q;

      always_comb begin
        vis_pipe_d = IN_LAT'({vis_pipe_q, vis_raw_s});
      end

      always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
          vis_pipe_q <= '0;
        end else begin
          vis_pipe_q <= vis_pipe_d;
        end
      end

      assign vis_al_s = vis_pipe_q[IN_LAT-1];
    end
  endgenerate

  always_comb begin
    if (player_pix != '0) begin
      pix_idx_s = player_pix;
    end else if (obstacle_pix != '0) begin
      pix_idx_s = obstacle_pix;
    end else begin
      pix_idx_s = level_pix;
    end

    if (vis_al_s) begin
      rgb_d = palette(pix_idx_s);
    end else begin
      rgb_d = 12'h000;
    end

    running_s = (state >= 4'd5) && (state <= 4'd10);
    overlap_s = running_s && vis_al_s && (player_pix != '0) && (obstacle_pix != '0);
    eof_s     = (hc == 10'd0) && (vc == EOF_V);

    // End of frame clears the counter even if an overlap lands on the same cycle.
    if (eof_s) begin
      hit_d  = 8'd0;
      flag_d = 1'b0;
    end else begin
      if (overlap_s && (hit_q != 8'hFF)) begin
        hit_d = hit_q + 8'd1;
      end else begin
        hit_d = hit_q;
      end
      flag_d = flag_q || (hit_d >= COLL_THR);
    end

    tick_d = eof_s;
    coll_d = eof_s && flag_q;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      rgb_q  <= 12'h000;
      hit_q  <= 8'd0;
      flag_q <= 1'b0;
      tick_q <= 1'b0;
      coll_q <= 1'b0;
    end else begin
      rgb_q  <= rgb_d;
      hit_q  <= hit_d;
      flag_q <= flag_d;
      tick_q <= tick_d;
      coll_q <= coll_d;
    end
  end

  assign vgaR       = rgb_q[11:8];
  assign vgaG       = rgb_q[7:4];
  assign vgaB       = rgb_q[3:0];
  assign frame_tick = tick_q;
  assign collision  = coll_q;
  assign hit_count  = hit_q;

endmodule
